wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master, one-slave Wishbone arbiter for the 16-bit CPU bus. It shares a single slave port (memory/peripheral fabric) between the instruction-fetch master (m0) and the load/store master (m1).
- Arbitration is round-robin.
- A grant is held for a whole cyc-framed cycle.
- A watchdog terminates transfers the slave never acknowledges.

Parameters:
- ADR_W, 16, address width
- DAT_W, 16, data width
- SEL_W, 4, byte/lane select width
- TIMEOUT, 16, cycles with stb high and no ack before the transfer is aborted (must be ≥2)

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- m0_adr_i / m1_adr_i  in  ADR_W  master address
- m0_dat_i / m1_dat_i  in  DAT_W  master write data
- m0_we_i / m1_we_i  in  1  0 = read, 1 = write
- m0_sel_i / m1_sel_i  in  SEL_W  lane select
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  bus cycle request
- m0_dat_o / m1_dat_o  out  DAT_W  read data returned to master
- m0_ack_o / m1_ack_o  out  1  transfer acknowledge
- m0_err_o / m1_err_o  out  1  timeout abort, one-cycle pulse
- s_adr_o  out  ADR_W  address to slave
- s_dat_o  out  DAT_W  write data to slave
- s_we_o  out  1  write enable to slave
- s_sel_o  out  SEL_W  lane select to slave
- s_stb_o  out  1  strobe to slave
- s_cyc_o  out  1  cycle to slave
- s_dat_i  in  DAT_W  read data from slave
- s_ack_i  in  1  acknowledge from slave
- gnt_o  out  2  one-hot current grant (debug/perf counters)

Behaviour:
- State machine states: IDLE, GNT0, GNT1. State, last_gnt and wd_cnt are registered; all bus routing is combinational from the state.
- Reset values: state = IDLE, last_gnt = 1 (so m0 wins the first tie), wd_cnt = 0.
- Outputs while reset is high or in IDLE: all s_* = 0, all m*_ack_o/m*_err_o = 0, m*_dat_o = 0, gnt_o = 00.
- Transitions out of IDLE:
  - If m0_cyc_i and m1_cyc_i are both high, grant the master with index != last_gnt.
  - Otherwise grant whichever master requests.
  - Latency: cyc sampled high at edge N gives s_cyc_o high from cycle N+1. No combinational grant.
- In GNTk:
  - s_* are driven from mk_*. s_cyc_o = mk_cyc_i; s_stb_o = mk_stb_i.
  - mk_ack_o = s_ack_i; mk_dat_o = s_dat_i.
  - The other master sees ack = 0, err = 0, dat = 0, and its stb never reaches the slave.
  - gnt_o = one-hot(k).
- Grant release: when mk_cyc_i is sampled low in GNTk, go to IDLE next cycle and set last_gnt = k. There is one dead IDLE cycle between grants, so back-to-back cycles from different masters are ≥1 cycle apart.
- Burst/pipelined accesses: the master may issue multiple stb/ack pairs under one cyc; the grant is held throughout.
- Watchdog:
  - wd_cnt increments each cycle in GNTk with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i=1, on stb low, and on leaving GNTk.
  - When wd_cnt == TIMEOUT-1 and ack is still low, pulse mk_err_o for that cycle. mk_ack_o is suppressed that cycle; the next state is IDLE and last_gnt = k.
- Simultaneous ack and timeout on the same cycle: ack wins, no err.
- Aborted master still holding cyc: it is treated as a fresh request in IDLE and arbitrated normally. If the other master is requesting, the other master wins.
- Reset asserted mid-transfer: next cycle is IDLE with all outputs deasserted. An in-flight slave ack is dropped.
- Invariants:
  - s_cyc_o is never high in IDLE.
  - At most one of m0_ack_o/m1_ack_o is high in any cycle.
  - ack and err are never simultaneously high for the same master.

Decomposition:
- Shared package wb_pkg: typedef arb_state_e {IDLE, GNT0, GNT1}; localparams WB_ADR_W=16, WB_DAT_W=16, WB_SEL_W=4.
- One natural sub-module, wb_watchdog: counter with clear/enable inputs, parameter TIMEOUT, and an expire output pulse.
- Arbiter FSM and muxing stay in wb_arbiter2.

Test Plan:
1. Single master read: m0 cyc/stb, adr=0x0040, slave acks on the 2nd cycle with dat=0xBEEF → s_cyc_o rises 1 cycle after m0 cyc, m0_ack_o=1 with m0_dat_o=0xBEEF, gnt_o=01, m1 outputs stay 0.
2. Tie after reset: m0 and m1 raise cyc on the same edge → m0 granted first. m1 is granted in the cycle after m0 drops cyc plus the IDLE cycle. A second simultaneous tie then goes to m1 (alternation).
3. Burst hold: m1 holds cyc for 4 stb/ack pairs (writes 0x1111..0x4444 at 0x0100..0x0103) while m0 requests → m0 is not granted until m1 drops cyc. The slave sees all 4 writes in order with we=1 and sel=4'hF.
4. Timeout: TIMEOUT=16, m0 read, slave never acks → m0_err_o pulses exactly on the 16th stb cycle, no ack. Next cycle IDLE. If m1 is requesting it wins, otherwise m0 is re-granted.
5. Ack on the timeout cycle: slave acks at wd_cnt=TIMEOUT-1 → m0_ack_o=1 and m0_err_o=0.
6. Reset mid-transfer: assert reset while GNT1 with stb high → next cycle s_cyc_o=0, gnt_o=00, and the next tie goes to m0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the 16-bit CPU bus fabric.
// Holds the arbiter state encoding and default bus widths.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles and flags the last allowed one.
// The owner clears it on grant release; a low enable also restarts the count.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Expiry is only meaningful while a stalled strobe is still outstanding.
  assign o_expire = i_en && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset || i_clr || !i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter sharing one slave port.
// Grant is held for a whole cyc frame; a watchdog aborts unacknowledged strobes.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int SEL_W   = WB_SEL_W,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  arb_state_e r_state;
  logic       r_last_gnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_stb_sel;
  logic w_cyc_sel;
  logic w_wd_en;
  logic w_expire;
  logic w_release;

  // Reset gates routing directly so nothing leaks to the slave while it is held.
  assign w_gnt0    = !reset && (r_state == GNT0);
  assign w_gnt1    = !reset && (r_state == GNT1);
  assign w_stb_sel = (w_gnt0 && m0_stb_i) || (w_gnt1 && m1_stb_i);
  assign w_cyc_sel = (w_gnt0 && m0_cyc_i) || (w_gnt1 && m1_cyc_i);
  assign w_wd_en   = w_stb_sel && !s_ack_i;
  assign w_release = (w_gnt0 || w_gnt1) && (!w_cyc_sel || w_expire);
  assign gnt_o     = {w_gnt1, w_gnt0};

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_wd_en),
    .i_clr    (w_release),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_last_gnt ? GNT0 : GNT1;
          end else if (m0_cyc_i) begin
            r_state <= GNT0;
          end else if (m1_cyc_i) begin
            r_state <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i || w_expire) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_cyc_i || w_expire) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = w_stb_sel;
    s_cyc_o  = w_cyc_sel;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (w_gnt0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i && !w_expire;
      m0_err_o = w_expire;
    end else if (w_gnt1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i && !w_expire;
      m1_err_o = w_expire;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic
// compared every cycle against an ownership/stall-count reference model.
module tb_wb_arbiter2;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
  logic [3:0]  m0_sel, m1_sel;
  logic [15:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_err_seen = 0;

  // Reference model: current owner (-1 = nobody), last served master, stalled strobe cycles.
  int own = -1;
  int last = 1;
  int stall = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .gnt_o(gnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks this cycle, then advances.
  task automatic step();
    logic        c[2], s[2], w[2];
    logic [15:0] a[2], d[2];
    logic [3:0]  l[2];
    logic [15:0] e_adr, e_wdat;
    logic        e_we, e_stb, e_cyc, tmo;
    logic [3:0]  e_sel;
    logic [1:0]  e_gnt, e_ack, e_err;
    logic [15:0] e_rdat[2];
    c[0] = m0_cyc; s[0] = m0_stb; w[0] = m0_we; a[0] = m0_adr; d[0] = m0_dat; l[0] = m0_sel;
    c[1] = m1_cyc; s[1] = m1_stb; w[1] = m1_we; a[1] = m1_adr; d[1] = m1_dat; l[1] = m1_sel;
    e_adr = '0; e_wdat = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0; e_sel = '0;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rdat[0] = '0; e_rdat[1] = '0; tmo = 1'b0;
    #1;
    if (!reset && own >= 0) begin
      e_adr = a[own]; e_wdat = d[own]; e_we = w[own]; e_sel = l[own];
      e_stb = s[own]; e_cyc = c[own];
      tmo = s[own] && !s_ack && (stall == TIMEOUT - 1);
      e_ack[own] = s_ack && !tmo;
      e_err[own] = tmo;
      e_rdat[own] = s_dat;
      e_gnt[own] = 1'b1;
    end
    check("s_adr", 32'(s_adr_o), 32'(e_adr));
    check("s_dat", 32'(s_dat_o), 32'(e_wdat));
    check("s_we", 32'(s_we_o), 32'(e_we));
    check("s_sel", 32'(s_sel_o), 32'(e_sel));
    check("s_stb", 32'(s_stb_o), 32'(e_stb));
    check("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
    check("gnt", 32'(gnt_o), 32'(e_gnt));
    check("ack", 32'({m1_ack_o, m0_ack_o}), 32'(e_ack));
    check("err", 32'({m1_err_o, m0_err_o}), 32'(e_err));
    check("m0_dat", 32'(m0_dat_o), 32'(e_rdat[0]));
    check("m1_dat", 32'(m1_dat_o), 32'(e_rdat[1]));
    if (m0_err_o || m1_err_o) n_err_seen++;
    if (reset) begin
      own = -1; last = 1; stall = 0;
    end else if (own < 0) begin
      stall = 0;
      if (c[0] && c[1]) own = 1 - last;
      else if (c[0]) own = 0;
      else if (c[1]) own = 1;
    end else if (!c[own] || tmo) begin
      last = own; own = -1; stall = 0;
    end else begin
      stall = (s[own] && !s_ack) ? stall + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic rand_master(input int mode, inout logic cyc, output logic stb,
                             output logic we, output logic [15:0] adr,
                             output logic [15:0] dat, output logic [3:0] sel);
    if (cyc) begin
      if ($urandom_range(0, (mode == 1) ? 40 : 15) == 0) cyc = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      cyc = 1'b1;
    end
    stb = cyc && ((mode == 1) || ($urandom_range(0, 3) != 0));
    we  = 1'($urandom);
    adr = 16'($urandom);
    dat = 16'($urandom);
    sel = 4'($urandom);
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_ack = 0; s_dat = '0;
  endtask

  initial begin
    int mode;
    reset = 1'b1;
    idle_masters();
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();

    // Single master read, slave acks on the second granted cycle.
    m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0040; m0_sel = 4'hF;
    step(); step();
    s_ack = 1; s_dat = 16'hBEEF;
    step();
    idle_masters();
    step(); step();

    // Tie after a served m0, then a second tie alternates.
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    step(); step(); step();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step(); step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step(); step();
    idle_masters();
    step(); step();

    // Burst of four writes from m1 while m0 waits.
    m1_cyc = 1; m1_we = 1; m1_sel = 4'hF;
    step();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 4; i++) begin
      m1_stb = 1; m1_adr = 16'h0100 + 16'(i); m1_dat = 16'h1111 * 16'(i + 1); s_ack = 1;
      step();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step(); step(); step();
    idle_masters();
    step(); step();

    // Timeout with nobody else requesting, then with m1 requesting.
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 20; i++) step();
    m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 20; i++) step();
    idle_masters();
    step(); step();

    // Ack arrives on the last allowed stall cycle.
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    s_ack = 1; s_dat = 16'h5A5A;
    step();
    idle_masters();
    step(); step();

    // Reset during a GNT1 strobe, then a tie.
    m1_cyc = 1; m1_stb = 1;
    step(); step();
    s_ack = 1; reset = 1;
    step();
    reset = 0; s_ack = 0; m0_cyc = 1; m0_stb = 1;
    step(); step(); step();
    idle_masters();
    step();

    for (int i = 0; i < 3000; i++) begin
      mode = (i / 400) % 3;
      rand_master(mode, m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel);
      rand_master(mode, m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel);
      case (mode)
        0:       s_ack = 1'($urandom);
        1:       s_ack = ($urandom_range(0, 39) == 0);
        default: s_ack = ($urandom_range(0, 7) == 0);
      endcase
      s_dat = 16'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    check("saw_timeout", 32'(n_err_seen > 0), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
